// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - linear frequency sweep sequencer driving one dds instance
// Latches a sweep config on start, arms the dds phase, then steps the tuning word every dwell+1 cycles.
module dds_sweep_ctrl #(
  parameter int TW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [TW-1:0] cfg_f_start,
  input  logic [TW-1:0] cfg_f_stop,
  input  logic [TW-1:0] cfg_f_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [1:0]    cfg_mode,
  output logic          dds_ce,
  output logic          dds_rst,
  output logic [TW-1:0] dds_tuning_word,
  output logic          busy,
  output logic          done,
  output logic          wrap,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [1:0] MODE_SAW = 2'd1;
  localparam logic [1:0] MODE_TRI = 2'd2;

  state_t        state_q, state_n;
  logic [TW-1:0] tw_q, tw_n;
  logic [DW-1:0] cnt_q, cnt_n;
  logic          dir_up_q, dir_up_n;
  logic [TW-1:0] fs_q, fs_n, fe_q, fe_n, step_q, step_n;
  logic [DW-1:0] dwell_q, dwell_n;
  logic [1:0]    mode_q, mode_n;
  logic          ce_n, arm_n, busy_n, done_n, wrap_n, err_n;

  logic [TW:0]   up_sum, dn_lim;
  logic [TW-1:0] up_next, dn_next;
  logic          tone, cfg_bad;

  // Widened by one bit so the clamp compares cannot be fooled by wraparound.
  assign up_sum  = {1'b0, tw_q} + {1'b0, step_q};
  assign up_next = (up_sum >= {1'b0, fe_q}) ? fe_q : up_sum[TW-1:0];
  assign dn_lim  = {1'b0, fs_q} + {1'b0, step_q};
  assign dn_next = ({1'b0, tw_q} < dn_lim) ? fs_q : tw_q - step_q;
  assign tone    = (fs_q == fe_q);
  assign cfg_bad = (cfg_f_start > cfg_f_stop) ||
                   ((cfg_f_step == '0) && (cfg_f_start != cfg_f_stop));

  always_comb begin
    state_n  = state_q;
    tw_n     = tw_q;
    cnt_n    = cnt_q;
    dir_up_n = dir_up_q;
    fs_n     = fs_q;
    fe_n     = fe_q;
    step_n   = step_q;
    dwell_n  = dwell_q;
    mode_n   = mode_q;
    wrap_n   = 1'b0;
    err_n    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_n = 1'b1;
          end else begin
            fs_n     = cfg_f_start;
            fe_n     = cfg_f_stop;
            step_n   = cfg_f_step;
            dwell_n  = cfg_dwell;
            mode_n   = cfg_mode;
            tw_n     = cfg_f_start;
            cnt_n    = cfg_dwell;
            dir_up_n = 1'b1;
            state_n  = S_ARM;
          end
        end
      end
      S_ARM: begin
        state_n = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_n = cnt_q - DW'(1);
        end else begin
          cnt_n = dwell_q;
          if (dir_up_q) begin
            if (tw_q == fe_q) begin
              // Dwell at f_stop has completed: segment end.
              if (mode_q == MODE_SAW) begin
                if (!tone) begin
                  tw_n   = fs_q;
                  wrap_n = 1'b1;
                end
              end else if (mode_q == MODE_TRI) begin
                if (!tone) begin
                  tw_n = dn_next;
                  if (dn_next == fs_q) wrap_n = 1'b1;
                  else                 dir_up_n = 1'b0;
                end
              end else begin
                state_n = S_DONE;
              end
            end else begin
              tw_n = up_next;
            end
          end else begin
            tw_n = dn_next;
            if (dn_next == fs_q) begin
              dir_up_n = 1'b1;
              wrap_n   = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    ce_n   = (state_n == S_RUN);
    arm_n  = (state_n == S_ARM);
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      tw_q            <= '0;
      cnt_q           <= '0;
      dir_up_q        <= 1'b0;
      fs_q            <= '0;
      fe_q            <= '0;
      step_q          <= '0;
      dwell_q         <= '0;
      mode_q          <= '0;
      dds_ce          <= 1'b0;
      dds_rst         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      wrap            <= 1'b0;
      err             <= 1'b0;
    end else begin
      state_q         <= state_n;
      tw_q            <= tw_n;
      cnt_q           <= cnt_n;
      dir_up_q        <= dir_up_n;
      fs_q            <= fs_n;
      fe_q            <= fe_n;
      step_q          <= step_n;
      dwell_q         <= dwell_n;
      mode_q          <= mode_n;
      dds_ce          <= ce_n;
      dds_rst         <= arm_n;
      busy            <= busy_n;
      done            <= done_n;
      wrap            <= wrap_n;
      err             <= err_n;
    end
  end

  assign dds_tuning_word = tw_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - table-driven bench for dds_sweep_ctrl
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [7:0]  cfg_f_start, cfg_f_stop, cfg_f_step;
  logic [15:0] cfg_dwell;
  logic [1:0]  cfg_mode;
  logic        dds_ce, dds_rst, busy, done, wrap, err;
  logic [7:0]  dds_tuning_word;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.TW(8), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .dds_ce(dds_ce), .dds_rst(dds_rst), .dds_tuning_word(dds_tuning_word),
    .busy(busy), .done(done), .wrap(wrap), .err(err)
  );

  typedef struct {
    logic        st, sp;
    logic [7:0]  fs, fe, stp;
    logic [15:0] dw;
    logic [1:0]  md;
    logic        ce, rs;
    logic [7:0]  tw;
    logic        bz, dn, wr, er;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  c_fs, c_fe, c_stp;
  logic [15:0] c_dw;
  logic [1:0]  c_md;

  function automatic void cfg(input logic [7:0] fs, fe, stp, input logic [15:0] dw, input logic [1:0] md);
    c_fs = fs; c_fe = fe; c_stp = stp; c_dw = dw; c_md = md;
  endfunction

  function automatic void v(input logic st, sp, ce, rs, input logic [7:0] tw, input logic bz, dn, wr, er);
    vec_t r;
    r.st = st; r.sp = sp; r.fs = c_fs; r.fe = c_fe; r.stp = c_stp; r.dw = c_dw; r.md = c_md;
    r.ce = ce; r.rs = rs; r.tw = tw; r.bz = bz; r.dn = dn; r.wr = wr; r.er = er;
    vecs.push_back(r);
  endfunction

  function automatic void run(input logic [7:0] tw, input logic wr);
    v(1'b0, 1'b0, 1'b1, 1'b0, tw, 1'b1, 1'b0, wr, 1'b0);
  endfunction

  function automatic void idle(input logic [7:0] tw);
    v(1'b0, 1'b0, 1'b0, 1'b0, tw, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got ce,rst,tw,busy,done,wrap,err=%b,%b,%0d,%b,%b,%b,%b required %b,%b,%0d,%b,%b,%b,%b",
               name, got[13], got[12], got[11:4], got[3], got[2], got[1], got[0],
               exp[13], exp[12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [13:0] outs();
    return {dds_ce, dds_rst, dds_tuning_word, busy, done, wrap, err};
  endfunction

  task automatic drive(input logic st, sp, input logic [7:0] fs, fe, stp, input logic [15:0] dw, input logic [1:0] md);
    start = st; stop = sp; cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = stp; cfg_dwell = dw; cfg_mode = md;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 16'd0, 2'd0);

    // Triangle with an ignored start/cfg change mid-run, then stop
    cfg(8'd10, 8'd20, 8'd4, 16'd1, 2'd2);
    v(1, 0, 0, 1, 8'd10, 1, 0, 0, 0);
    run(8'd10, 0); run(8'd10, 0);
    cfg(8'd50, 8'd60, 8'd1, 16'd0, 2'd0);
    v(1, 0, 1, 0, 8'd14, 1, 0, 0, 0);
    run(8'd14, 0); run(8'd18, 0); run(8'd18, 0); run(8'd20, 0); run(8'd20, 0);
    run(8'd16, 0); run(8'd16, 0); run(8'd12, 0); run(8'd12, 0);
    run(8'd10, 1); run(8'd10, 0); run(8'd14, 0);
    v(0, 1, 0, 0, 8'd14, 0, 0, 0, 0);
    v(0, 1, 0, 0, 8'd14, 0, 0, 0, 0);
    // Single, stop at the third RUN cycle
    cfg(8'd10, 8'd20, 8'd4, 16'd1, 2'd0);
    v(1, 0, 0, 1, 8'd10, 1, 0, 0, 0);
    run(8'd10, 0); run(8'd10, 0); run(8'd14, 0);
    v(0, 1, 0, 0, 8'd14, 0, 0, 0, 0);
    idle(8'd14);
    // Single, full sweep
    v(1, 0, 0, 1, 8'd10, 1, 0, 0, 0);
    run(8'd10, 0); run(8'd10, 0); run(8'd14, 0); run(8'd14, 0);
    run(8'd18, 0); run(8'd18, 0); run(8'd20, 0); run(8'd20, 0);
    v(0, 0, 0, 0, 8'd20, 1, 1, 0, 0);
    idle(8'd20);
    // Rejected starts
    cfg(8'd30, 8'd20, 8'd4, 16'd1, 2'd0);
    v(1, 0, 0, 0, 8'd20, 0, 0, 0, 1);
    idle(8'd20);
    cfg(8'd5, 8'd9, 8'd0, 16'd1, 2'd0);
    v(1, 0, 0, 0, 8'd20, 0, 0, 0, 1);
    idle(8'd20);
    // Tone in single mode
    cfg(8'd7, 8'd7, 8'd0, 16'd2, 2'd0);
    v(1, 0, 0, 1, 8'd7, 1, 0, 0, 0);
    run(8'd7, 0); run(8'd7, 0); run(8'd7, 0);
    v(0, 0, 0, 0, 8'd7, 1, 1, 0, 0);
    idle(8'd7);
    // Sawtooth near the top of the range; start and stop together while idle
    cfg(8'd250, 8'd255, 8'd4, 16'd0, 2'd1);
    v(1, 1, 0, 1, 8'd250, 1, 0, 0, 0);
    run(8'd250, 0); run(8'd254, 0); run(8'd255, 0); run(8'd250, 1);
    run(8'd254, 0); run(8'd255, 0); run(8'd250, 1);
    v(0, 1, 0, 0, 8'd250, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 check("reset_state", outs(), 14'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].sp, vecs[i].fs, vecs[i].fe, vecs[i].stp, vecs[i].dw, vecs[i].md);
      @(posedge clk);
      #1 check($sformatf("row%0d", i), outs(),
               {vecs[i].ce, vecs[i].rs, vecs[i].tw, vecs[i].bz, vecs[i].dn, vecs[i].wr, vecs[i].er});
    end

    // Reset in the middle of a sweep clears everything
    @(negedge clk) drive(1'b1, 1'b0, 8'd10, 8'd20, 8'd4, 16'd1, 2'd2);
    @(negedge clk) drive(1'b0, 1'b0, 8'd10, 8'd20, 8'd4, 16'd1, 2'd2);
    repeat (3) @(negedge clk);
    check("mid_run_before_reset", outs(), {1'b1, 1'b0, 8'd14, 1'b1, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b0;
    @(posedge clk);
    #1 check("mid_run_reset", outs(), 14'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_reset_idle", outs(), 14'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the DDS control inputs (ce, rst, tuning_word) to generate linear frequency sweeps: single-shot, sawtooth-repeat or triangle. It sits between a host/register block and one dds instance. It latches a sweep configuration on a start pulse, arms the DDS phase, then steps the tuning word every DWELL+1 cycles between F_START and F_STOP.

Parameters:
TW, 8, tuning word width; must match the dds TW.
DW, 16, dwell counter width.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
start  in  1  one-cycle pulse; latches cfg_* and begins a sweep when idle
stop  in  1  one-cycle pulse; aborts the sweep
cfg_f_start  in  TW  start tuning word
cfg_f_stop  in  TW  end tuning word
cfg_f_step  in  TW  tuning word increment per step
cfg_dwell  in  DW  extra cycles per step (a step lasts dwell+1 cycles)
cfg_mode  in  2  0=SINGLE, 1=SAWTOOTH, 2=TRIANGLE, 3=treated as SINGLE
dds_ce  out  1  to dds ce
dds_rst  out  1  to dds rst (loads start_phase)
dds_tuning_word  out  TW  to dds tuning_word
busy  out  1  high in ARM/RUN/DONE
done  out  1  one-cycle pulse at end of a SINGLE sweep
wrap  out  1  one-cycle pulse when a continuous sweep returns to f_start
err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge): state IDLE. dds_ce=0, dds_rst=0, dds_tuning_word=0, busy=0, done=0, wrap=0, err=0. Latched configuration is cleared. Reset applies mid-sweep with the same result.
- All outputs are registered. States are IDLE, ARM, RUN and DONE.
- IDLE + start:
  - Reject if cfg_f_start > cfg_f_stop, or if cfg_f_step == 0 while cfg_f_start != cfg_f_stop. On reject: err=1 for one cycle and stay IDLE.
  - Otherwise latch cfg_* and go to ARM.
- start while busy is ignored, and cfg_* changes while busy are ignored.
- ARM (exactly 1 cycle): dds_rst=1, dds_ce=0, dds_tuning_word=f_start, dwell counter loaded with dwell. Next state is RUN, direction up.
- RUN: dds_ce=1 every cycle. The dwell counter decrements each cycle. When it is 0, the next cycle loads a new tuning word and reloads the counter.
- Next-word arithmetic is done in TW+1 bits, so there is no overflow:
  - Up: tw+step >= f_stop gives f_stop (clamp); otherwise tw+step.
  - Down: tw < f_start+step gives f_start (clamp); otherwise tw-step.
- End-of-segment: the dwell at the clamp value has completed.
  - SINGLE, end at f_stop: go to DONE.
  - SAWTOOTH, end at f_stop: the next word is f_start, with wrap=1 in that cycle. There is no ARM, so phase stays continuous.
  - TRIANGLE, end at f_stop: direction becomes down.
  - TRIANGLE, end at f_start going down: direction becomes up, with wrap=1 in the cycle tw becomes f_start.
- f_start == f_stop (tone):
  - SINGLE: one dwell at f_start, then DONE.
  - SAWTOOTH/TRIANGLE: hold f_start indefinitely, with no wrap pulses.
- DONE (1 cycle): done=1, dds_ce=0, tuning word held. Next state IDLE.
- IDLE: dds_ce=0, dds_rst=0, tuning word holds its last value.
- stop in ARM/RUN: next cycle is IDLE, with dds_ce=0, busy=0 and no done pulse. stop in IDLE/DONE is ignored.
- start and stop in the same cycle while IDLE: start wins. When busy, stop wins.
- dwell=0 means the word changes every cycle.

Test Plan:
- SINGLE, f_start=10, f_stop=20, step=4, dwell=1 -> ARM one cycle with dds_rst=1 and tw=10. Then 8 RUN cycles with tw 10,10,14,14,18,18,20,20 and dds_ce=1. Then done=1 for one cycle, then IDLE, busy=0, tw=20.
- TRIANGLE, same config -> tw sequence 10,10,14,14,18,18,20,20,16,16,12,12,10,10,14,... with wrap=1 on the first 10 after the down leg. dds_rst pulses only once.
- SAWTOOTH, f_start=250, f_stop=255, step=4, dwell=0, TW=8 -> 250,254,255,250,254,... with no 8-bit overflow, and wrap=1 on each return to 250.
- Reject cases: start with f_start=30, f_stop=20 -> err pulse, busy stays 0. start with step=0, f_start=5, f_stop=9 -> err pulse. step=0, f_start=f_stop=7, SINGLE, dwell=2 -> 3 RUN cycles at 7, then done.
- Abort and reset: stop at the 3rd RUN cycle -> next cycle dds_ce=0, busy=0, no done. rst_n=0 mid-RUN -> all outputs 0 next cycle. start during RUN with new cfg -> ignored, and the sequence is unchanged.
